// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcode map, sequencer states, IR field positions
// and the control-strobe bundle produced by the step decoder.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_OR   = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  localparam logic [4:0] OP_MAX = 5'd12;

  localparam int unsigned IR_OP_HI = 31;
  localparam int unsigned IR_OP_LO = 27;
  localparam int unsigned IR_RA_HI = 26;
  localparam int unsigned IR_RA_LO = 23;
  localparam int unsigned IR_RB_HI = 22;
  localparam int unsigned IR_RB_LO = 19;
  localparam int unsigned IR_RC_HI = 18;
  localparam int unsigned IR_RC_LO = 15;

  typedef enum logic [2:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       pc_in;
    logic       mem_read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       zlo_out;
    logic       zhi_out;
    logic       hi_in;
    logic       lo_in;
    logic       rf_out;
    logic       rf_in;
    logic [3:0] rf_sel;
    logic [3:0] alu_control;
    logic       busy;
    logic       done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_MAX;
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == {1'b0, ALU_MUL}) || (op == {1'b0, ALU_DIV});
  endfunction

  // NEG/NOT operate on Y alone, so no second register is put on the bus.
  function automatic logic is_unary(input logic [4:0] op);
    return (op == {1'b0, ALU_NEG}) || (op == {1'b0, ALU_NOT});
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction handshake in, control strobes out.
interface alu_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             mem_ready;
  logic [31:0]      ir;
  logic             pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in;
  logic             y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
  logic             rf_out, rf_in;
  logic [3:0]       rf_sel;
  logic [3:0]       alu_control;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, mem_ready, ir,
    output pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, rf_out, rf_in,
           rf_sel, alu_control, busy, done, illegal, retired
  );

  modport slave (
    output start, mem_ready, ir,
    input  pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, rf_out, rf_in,
           rf_sel, alu_control, busy, done, illegal, retired
  );
endinterface

// File: rtl/alu_sequencer_ctrl_decode.sv
// Combinational step decoder: current control step + IR fields -> strobes.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [4:0] op,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl      = '0;
    ctrl.busy = (state != ST_IDLE);
    case (state)
      ST_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      ST_T1: begin
        // PC update from Z only on the cycle memory completes.
        ctrl.mem_read = 1'b1;
        ctrl.mdr_in   = 1'b1;
        ctrl.zlo_out  = mem_ready;
        ctrl.pc_in    = mem_ready;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (is_illegal(op)) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.rf_out = 1'b1;
          ctrl.rf_sel = rb;
          ctrl.y_in   = 1'b1;
        end
      end
      ST_T4: begin
        ctrl.z_in        = 1'b1;
        ctrl.alu_control = op[3:0];
        if (!is_unary(op)) begin
          ctrl.rf_out = 1'b1;
          ctrl.rf_sel = rc;
        end
      end
      ST_T5: begin
        ctrl.zlo_out = 1'b1;
        if (is_muldiv(op)) begin
          ctrl.lo_in = 1'b1;
        end else begin
          ctrl.rf_in  = 1'b1;
          ctrl.rf_sel = ra;
          ctrl.done   = 1'b1;
        end
      end
      ST_T6: begin
        ctrl.zhi_out = 1'b1;
        ctrl.hi_in   = 1'b1;
        ctrl.done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control-step sequencer for one register-register ALU instruction.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           clear,
  alu_sequencer_if.master bus
);

  state_t           state;
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  ctrl_t            ctrl;

  assign op = bus.ir[IR_OP_HI:IR_OP_LO];
  assign ra = bus.ir[IR_RA_HI:IR_RA_LO];
  assign rb = bus.ir[IR_RB_HI:IR_RB_LO];
  assign rc = bus.ir[IR_RC_HI:IR_RC_LO];

  ctrl_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      retired_q <= '0;
    end else begin
      if (ctrl.done) retired_q <= retired_q + CNT_W'(1);
      case (state)
        ST_IDLE: if (bus.start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (bus.mem_ready) state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3:   state <= is_illegal(op) ? ST_IDLE : ST_T4;
        ST_T4:   state <= ST_T5;
        ST_T5:   state <= is_muldiv(op) ? ST_T6 : ST_IDLE;
        ST_T6:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc_out      = ctrl.pc_out;
  assign bus.mar_in      = ctrl.mar_in;
  assign bus.inc_pc      = ctrl.inc_pc;
  assign bus.pc_in       = ctrl.pc_in;
  assign bus.mem_read    = ctrl.mem_read;
  assign bus.mdr_in      = ctrl.mdr_in;
  assign bus.mdr_out     = ctrl.mdr_out;
  assign bus.ir_in       = ctrl.ir_in;
  assign bus.y_in        = ctrl.y_in;
  assign bus.z_in        = ctrl.z_in;
  assign bus.zlo_out     = ctrl.zlo_out;
  assign bus.zhi_out     = ctrl.zhi_out;
  assign bus.hi_in       = ctrl.hi_in;
  assign bus.lo_in       = ctrl.lo_in;
  assign bus.rf_out      = ctrl.rf_out;
  assign bus.rf_in       = ctrl.rf_in;
  assign bus.rf_sel      = ctrl.rf_sel;
  assign bus.alu_control = ctrl.alu_control;
  assign bus.busy        = ctrl.busy;
  assign bus.done        = ctrl.done;
  assign bus.illegal     = ctrl.illegal;
  assign bus.retired     = retired_q;

endmodule
